// File: rtl/spi_sample_rx.sv
// SPI slave receiver: any SPI mode, configurable word width and bit order,
// first-word-fall-through FIFO output and echo of the last completed word on MISO.
module spi_sample_rx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic                          clk_25mhz,
  input  logic                          reset_n,
  input  logic                          com_sclk_in,
  input  logic                          com_mosi_in,
  input  logic                          com_active,
  output logic                          com_miso_out,
  output logic [DATA_W-1:0]             sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic                          frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  // Equal-depth synchronisers keep MOSI aligned with the detected SCLK edge.
  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync, cs_sync;

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= {3{CPOL}};
      mosi_sync <= '0;
      cs_sync   <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[1:0], com_sclk_in};
      mosi_sync <= {mosi_sync[0], com_mosi_in};
      cs_sync   <= {cs_sync[0], com_active};
    end
  end

  logic sclk_chg, lead_edge, trail_edge, sample_edge, shift_edge, mosi_s, cs_s;
  assign sclk_chg    = sclk_sync[1] != sclk_sync[2];
  assign lead_edge   = sclk_chg && (sclk_sync[2] == CPOL);
  assign trail_edge  = sclk_chg && (sclk_sync[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign mosi_s      = mosi_sync[1];
  assign cs_s        = cs_sync[1];

  state_t            state;
  logic [CW-1:0]     bit_cnt, tx_cnt, tx_cnt_next;
  logic [DATA_W-1:0] rx_sr, tx_sr, last_word, rx_next, tx_next;
  logic              miso_next, push;

  assign rx_next     = shl(rx_sr, mosi_s);
  assign push        = (state == ACTIVE) && !cs_s && sample_edge && (bit_cnt == LAST_BIT);
  assign tx_cnt_next = (tx_cnt == LAST_BIT) ? '0 : tx_cnt + 1'b1;

  // CPHA=1 presents the bit on the leading edge, so the word reload happens
  // lazily at the first shift of the next word, after last_word has updated.
  always_comb begin
    tx_next   = shl(tx_sr, 1'b0);
    miso_next = head_bit(tx_next);
    if (CPHA) begin
      tx_next   = shl((tx_cnt == '0) ? last_word : tx_sr, 1'b0);
      miso_next = head_bit((tx_cnt == '0) ? last_word : tx_sr);
    end else if (tx_cnt == LAST_BIT) begin
      tx_next   = last_word;
      miso_next = head_bit(last_word);
    end
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tx_cnt       <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      last_word    <= '0;
      com_miso_out <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          com_miso_out <= 1'b0;
          if (!cs_s) begin
            state        <= ACTIVE;
            bit_cnt      <= '0;
            tx_cnt       <= '0;
            rx_sr        <= '0;
            tx_sr        <= last_word;
            com_miso_out <= head_bit(last_word);
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            state        <= IDLE;
            com_miso_out <= 1'b0;
            frame_error  <= (bit_cnt != '0);
          end else begin
            if (sample_edge) begin
              if (bit_cnt == LAST_BIT) begin
                bit_cnt   <= '0;
                rx_sr     <= '0;
                last_word <= rx_next;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                rx_sr   <= rx_next;
              end
            end
            if (shift_edge) begin
              tx_sr        <= tx_next;
              tx_cnt       <= tx_cnt_next;
              com_miso_out <= miso_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO: a push into a full FIFO still lands if the head is popped that cycle.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              pop, full, wr_en;

  assign sample_valid = fifo_level != '0;
  assign sample_data  = mem[rd_ptr];
  assign pop          = sample_valid && sample_ready;
  assign full         = fifo_level == FULL_LVL;
  assign wr_en        = push && (!full || pop);

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_en) begin
        mem[wr_ptr] <= rx_next;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx: mode 0 in both bit orders, mode 3 with echo,
// FIFO overrun, short frames and mid-word reset.
module tb_spi_sample_rx;
  localparam int HALF = 6;

  logic clk_25mhz = 1'b0;
  always #5 clk_25mhz = ~clk_25mhz;

  logic reset_n, sclk_a, sclk_b, mosi, cs_a, cs_b, rdy0, rdy1, rdy2;
  logic miso0, miso1, miso2, valid0, valid1, valid2;
  logic ov0, ov1, ov2, fe0, fe1, fe2;
  logic [15:0] data0, data1, data2;
  logic [2:0]  level0, level1, level2;

  spi_sample_rx #(.DATA_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1'b1), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk_25mhz(clk_25mhz), .reset_n(reset_n), .com_sclk_in(sclk_a), .com_mosi_in(mosi),
    .com_active(cs_a), .com_miso_out(miso0), .sample_data(data0), .sample_valid(valid0),
    .sample_ready(rdy0), .fifo_level(level0), .overrun(ov0), .frame_error(fe0));

  spi_sample_rx #(.DATA_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1'b0), .CPOL(1'b0), .CPHA(1'b0)) dut1 (
    .clk_25mhz(clk_25mhz), .reset_n(reset_n), .com_sclk_in(sclk_a), .com_mosi_in(mosi),
    .com_active(cs_a), .com_miso_out(miso1), .sample_data(data1), .sample_valid(valid1),
    .sample_ready(rdy1), .fifo_level(level1), .overrun(ov1), .frame_error(fe1));

  spi_sample_rx #(.DATA_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1'b1), .CPOL(1'b1), .CPHA(1'b1)) dut2 (
    .clk_25mhz(clk_25mhz), .reset_n(reset_n), .com_sclk_in(sclk_b), .com_mosi_in(mosi),
    .com_active(cs_b), .com_miso_out(miso2), .sample_data(data2), .sample_valid(valid2),
    .sample_ready(rdy2), .fifo_level(level2), .overrun(ov2), .frame_error(fe2));

  int errors = 0, checks = 0;
  logic [15:0] q0[$], q1[$], q2[$];
  int ov0_n = 0, fe0_n = 0, fe1_n = 0, fe2_n = 0;

  // Handshakes are recorded mid-cycle; they complete on the following rising edge.
  always @(negedge clk_25mhz) begin
    if (valid0 && rdy0) q0.push_back(data0);
    if (valid1 && rdy1) q1.push_back(data1);
    if (valid2 && rdy2) q2.push_back(data2);
    if (ov0) ov0_n <= ov0_n + 1;
    if (fe0) fe0_n <= fe0_n + 1;
    if (fe1) fe1_n <= fe1_n + 1;
    if (fe2) fe2_n <= fe2_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_25mhz); #1; end
  endtask

  task automatic bit_a(input logic b, output logic m);
    mosi = b; tick(HALF); m = miso0; sclk_a = 1'b1; tick(HALF); sclk_a = 1'b0;
  endtask

  task automatic word_a(input logic [15:0] w, input int n, output logic [15:0] echo);
    logic m;
    echo = '0;
    for (int i = 0; i < n; i++) begin bit_a(w[15-i], m); echo = {echo[14:0], m}; end
  endtask

  task automatic bit_b(input logic b, output logic m);
    sclk_b = 1'b0; mosi = b; tick(HALF); m = miso2; sclk_b = 1'b1; tick(HALF);
  endtask

  task automatic word_b(input logic [15:0] w, output logic [15:0] echo);
    logic m;
    echo = '0;
    for (int i = 15; i >= 0; i--) begin bit_b(w[i], m); echo = {echo[14:0], m}; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cs_a = 1'b1; cs_b = 1'b1; sclk_a = 1'b0; sclk_b = 1'b1; mosi = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b1; rdy2 = 1'b1;
    tick(3);
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid0); end
    checks++; if (data0 !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", data0); end
    checks++; if (level0 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level0); end
    checks++; if ({miso0, ov0, fe0, miso2} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {miso0, ov0, fe0, miso2}); end
    reset_n = 1'b1;
    tick(4);
  endtask

  task automatic test_mode0;
    int b0, b1, f0;
    logic [15:0] e, got;
    rdy0 = 1'b1; b0 = q0.size(); b1 = q1.size(); f0 = fe0_n;
    cs_a = 1'b0; tick(HALF); word_a(16'hA5C3, 16, e); tick(HALF); cs_a = 1'b1; tick(8);
    checks++; if (q0.size() - b0 != 1) begin errors++; $display("FAIL mode0_beats: got %0d want 1", q0.size() - b0); end
    got = (q0.size() > b0) ? q0[b0] : 16'hxxxx;
    checks++; if (got !== 16'hA5C3) begin errors++; $display("FAIL mode0_msb_data: got %h want a5c3", got); end
    got = (q1.size() > b1) ? q1[b1] : 16'hxxxx;
    checks++; if (got !== 16'hC3A5) begin errors++; $display("FAIL mode0_lsb_data: got %h want c3a5", got); end
    checks++; if (fe0_n != f0 || level0 !== 3'd0) begin errors++; $display("FAIL mode0_idle: fe %0d level %0d want 0 0", fe0_n - f0, level0); end
  endtask

  task automatic test_fifo_overrun;
    int b0, o0;
    logic m;
    logic [15:0] e, got;
    rdy0 = 1'b0; b0 = q0.size(); o0 = ov0_n;
    cs_a = 1'b0; tick(HALF);
    for (int i = 15; i >= 1; i--) bit_a(1'b0, m);
    mosi = 1'b1; tick(HALF); sclk_a = 1'b1; tick(2);
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL latency_early: valid %0b want 0", valid0); end
    tick(1);
    checks++; if (valid0 !== 1'b1 || data0 !== 16'h0001) begin errors++; $display("FAIL latency_word: valid %0b data %h want 1 0001", valid0, data0); end
    tick(HALF - 3); sclk_a = 1'b0;
    for (int w = 2; w <= 4; w++) word_a(16'(w), 16, e);
    checks++; if (level0 !== 3'd4 || ov0_n != o0) begin errors++; $display("FAIL fifo_full: level %0d ov %0d want 4 0", level0, ov0_n - o0); end
    word_a(16'h0005, 16, e);
    checks++; if (level0 !== 3'd4 || ov0_n - o0 != 1) begin errors++; $display("FAIL overrun_pulse: level %0d ov %0d want 4 1", level0, ov0_n - o0); end
    // 0x0006 completes in the same cycle the head is popped: accepted, no overrun
    for (int i = 15; i >= 1; i--) bit_a((i == 1 || i == 2) ? 1'b1 : 1'b0, m);
    mosi = 1'b0; tick(HALF); sclk_a = 1'b1; tick(2);
    rdy0 = 1'b1; tick(1); rdy0 = 1'b0;
    tick(HALF - 3); sclk_a = 1'b0; tick(HALF); cs_a = 1'b1; tick(6);
    checks++; if (level0 !== 3'd4 || ov0_n - o0 != 1) begin errors++; $display("FAIL push_pop_full: level %0d ov %0d want 4 1", level0, ov0_n - o0); end
    rdy0 = 1'b1; tick(8); rdy0 = 1'b0;
    checks++; if (q0.size() - b0 != 5) begin errors++; $display("FAIL drain_count: got %0d want 5", q0.size() - b0); end
    for (int i = 0; i < 5; i++) begin
      logic [15:0] want;
      want = (i == 4) ? 16'h0006 : 16'(i + 1);
      got = (q0.size() > b0 + i) ? q0[b0+i] : 16'hxxxx;
      checks++; if (got !== want) begin errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, got, want); end
    end
    checks++; if (level0 !== 3'd0 || valid0 !== 1'b0) begin errors++; $display("FAIL drain_empty: level %0d valid %0b want 0 0", level0, valid0); end
  endtask

  task automatic test_frame_error;
    int b0, f0, f1;
    logic [15:0] e, got;
    rdy0 = 1'b1; b0 = q0.size(); f0 = fe0_n; f1 = fe1_n;
    cs_a = 1'b0; tick(HALF); word_a(16'hABCD, 7, e); tick(HALF); cs_a = 1'b1; tick(8);
    checks++; if (fe0_n - f0 != 1 || fe1_n - f1 != 1) begin errors++; $display("FAIL short_frame: fe0 %0d fe1 %0d want 1 1", fe0_n - f0, fe1_n - f1); end
    checks++; if (q0.size() != b0 || level0 !== 3'd0) begin errors++; $display("FAIL short_no_push: words %0d level %0d want 0 0", q0.size() - b0, level0); end
    cs_a = 1'b0; tick(HALF); word_a(16'h1234, 16, e); tick(HALF); cs_a = 1'b1; tick(8);
    got = (q0.size() > b0) ? q0[b0] : 16'hxxxx;
    checks++; if (got !== 16'h1234 || fe0_n - f0 != 1) begin errors++; $display("FAIL after_short: data %h fe %0d want 1234 1", got, fe0_n - f0); end
    checks++; if (e !== 16'h0006) begin errors++; $display("FAIL mode0_echo: got %h want 0006", e); end
  endtask

  task automatic test_mode3;
    int b2, f2;
    logic [15:0] e1, e2, got;
    b2 = q2.size(); f2 = fe2_n;
    cs_b = 1'b0; tick(HALF); word_b(16'h1234, e1); word_b(16'hBEEF, e2); cs_b = 1'b1; tick(8);
    got = (q2.size() > b2) ? q2[b2] : 16'hxxxx;
    checks++; if (got !== 16'h1234) begin errors++; $display("FAIL mode3_word0: got %h want 1234", got); end
    got = (q2.size() > b2 + 1) ? q2[b2+1] : 16'hxxxx;
    checks++; if (got !== 16'hBEEF) begin errors++; $display("FAIL mode3_word1: got %h want beef", got); end
    checks++; if (e1 !== 16'h0000) begin errors++; $display("FAIL mode3_echo0: got %h want 0000", e1); end
    checks++; if (e2 !== 16'h1234) begin errors++; $display("FAIL mode3_echo1: got %h want 1234", e2); end
    checks++; if (fe2_n != f2 || level2 !== 3'd0) begin errors++; $display("FAIL mode3_idle: fe %0d level %0d want 0 0", fe2_n - f2, level2); end
  endtask

  task automatic test_reset_mid;
    int b0, f0;
    logic [15:0] e, got;
    rdy0 = 1'b0;
    cs_a = 1'b0; tick(HALF); word_a(16'h1111, 16, e); word_a(16'h2222, 16, e); word_a(16'hF0F0, 9, e);
    checks++; if (level0 !== 3'd2) begin errors++; $display("FAIL pre_reset_level: got %0d want 2", level0); end
    reset_n = 1'b0; #1;
    checks++; if ({valid0, miso0, ov0, fe0} !== 4'b0 || data0 !== 16'h0 || level0 !== 3'd0) begin
      errors++; $display("FAIL async_reset: v/m/o/f %b data %h level %0d want 0000 0000 0", {valid0, miso0, ov0, fe0}, data0, level0); end
    cs_a = 1'b1; tick(3); reset_n = 1'b1; tick(4);
    rdy0 = 1'b1; b0 = q0.size(); f0 = fe0_n;
    cs_a = 1'b0; tick(HALF); word_a(16'h00FF, 16, e); tick(HALF); cs_a = 1'b1; tick(8);
    got = (q0.size() > b0) ? q0[b0] : 16'hxxxx;
    checks++; if (got !== 16'h00FF || q0.size() - b0 != 1) begin errors++; $display("FAIL post_reset_frame: data %h words %0d want 00ff 1", got, q0.size() - b0); end
    checks++; if (fe0_n != f0 || level0 !== 3'd0) begin errors++; $display("FAIL post_reset_clean: fe %0d level %0d want 0 0", fe0_n - f0, level0); end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_fifo_overrun;
    test_frame_error;
    test_mode3;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_sample_rx.md
# spi_sample_rx

Parametrised SPI slave receiver for the audio link from the Pico: samples `com_sclk_in`/`com_mosi_in` in any of the four SPI modes, assembles words of configurable width in either bit order, and buffers completed words in a first-word-fall-through FIFO with a valid/ready output handshake. It replaces the fixed 16-bit, mode-0, single-register receiver at the FPGA side of the link. It adds overrun and short-frame detection, and echoes the most recently completed word back on MISO so the Pico can check the link.

## Interface
- `DATA_W`, 16: bits per word, 4..32.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, 2..64.
- `MSB_FIRST`, 1: 1 means the first received bit is the word MSB; 0 means it is the LSB.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 samples on the leading edge, 1 samples on the trailing edge.

- `clk_25mhz` input, 1: system clock; all logic is on its rising edge.
- `reset_n` input, 1: one clock; reset is asynchronous and active-low.
- `com_sclk_in` input, 1: SPI clock from the Pico, asynchronous.
- `com_mosi_in` input, 1: SPI data from the Pico, asynchronous.
- `com_active` input, 1: chip select, active-low, asynchronous.
- `com_miso_out` output, 1: echo data to the Pico.
- `sample_data` output, DATA_W: FIFO head word.
- `sample_valid` output, 1: FIFO is not empty.
- `sample_ready` input, 1: consumer accepts the head word.
- `fifo_level` output, clog2(FIFO_DEPTH)+1: number of stored words.
- `overrun` output, 1: one-cycle pulse when a completed word is dropped.
- `frame_error` output, 1: one-cycle pulse when CS rises with a partial word.

## Operation
- **Synchronisers:** SCLK, MOSI and CS each pass through a 2-FF synchroniser. A third SCLK flop provides edge detection. All three inputs have equal delay, so data stays aligned with its edge.
- **Edge definitions:**
  - Leading edge = SCLK leaving the CPOL level.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1.
  - Shift-out edge = the other edge.
- **FSM states:**
  - IDLE: synced CS low → ACTIVE; bit_cnt cleared, rx shift register cleared, tx shift register loaded from `last_word`.
  - ACTIVE: synced CS high → IDLE. If bit_cnt≠0 at that point, pulse `frame_error` and discard the partial word.
- **Receive (ACTIVE, each sample edge):**
  - Shift the synced MOSI in: at the LSB end if MSB_FIRST=1, at the MSB end if MSB_FIRST=0.
  - Increment bit_cnt.
  - When bit_cnt reaches DATA_W: the assembled word (including the current bit) is pushed to the FIFO and copied to `last_word`; bit_cnt wraps to 0.
  - Multiple words per CS frame are allowed.
- **Transmit:**
  - `com_miso_out` is registered and presents the tx-register bit in the same bit order as receive.
  - The tx register advances on each shift-out edge and reloads from `last_word` after every DATA_W shifts.
  - CPHA=0: first bit is valid from CS fall.
  - `com_miso_out` is 0 in IDLE.
- **FIFO:**
  - `sample_valid` = level≠0; `sample_data` = head entry.
  - A pop occurs when `sample_valid`&`sample_ready`.
  - A push is accepted if not full, or if a pop occurs in the same cycle; in that case level is unchanged.
  - Push while full with no pop: the word is dropped, `overrun` pulses, FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Reset (asynchronous, reset_n low):** FSM to IDLE; pointers, bit_cnt, shift registers and `last_word` to 0. Reset values of all outputs: `com_miso_out`=0, `sample_valid`=0, `sample_data`=0, `fifo_level`=0, `overrun`=0, `frame_error`=0. Reset mid-word discards all state with no pulses.

## Timing
- SCLK high and low times must each be ≥4 `clk_25mhz` periods, so SCLK ≤ 3.125 MHz.
- CS fall to first SCLK edge ≥4 periods; last SCLK edge to CS rise ≥4 periods.
- Receive latency: sample-edge pin transition to word in FIFO = 3 `clk_25mhz` rising edges (+1 for asynchronous sampling uncertainty). `sample_valid` rises the same cycle the word is written when the FIFO was empty.
- `overrun` and `frame_error` are exactly 1 cycle wide, registered.
- `com_miso_out` changes 3–4 cycles after the shift-out pin edge, which is within the half-period budget above.
- `fifo_level` updates in the cycle after a push or pop.

## Test plan
- Mode 0, MSB_FIRST=1, DATA_W=16, send 0xA5C3 with `sample_ready`=1 → one `sample_valid` beat with 0xA5C3, `frame_error`=0, level returns to 0.
- MSB_FIRST=0, same bit stream → `sample_data`=0xC3A5.
- FIFO_DEPTH=4, `sample_ready`=0, burst of 5 words 0x0001..0x0005 in one CS frame → level=4, one `overrun` pulse on the 5th word; draining yields 0x0001..0x0004 in order.
- CS rises after 7 bits → one `frame_error` pulse, nothing pushed; the next full frame 0x1234 is received correctly.
- CPOL=1, CPHA=1, two-word frame 0x1234 then 0xBEEF → both received; MISO bits during the second word decode to 0x1234.
- `reset_n` low after 9 bits with 2 words queued → all outputs 0 and level 0 immediately; after release, frame 0x00FF is received cleanly.
